// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the MEM-stage data-memory responder.
//   - FSM state encoding (IDLE/WAIT/RESP)
//   - default geometry and latency
//   - latched request record
//   - address legality helper
package dmem_responder_pkg;

  localparam int DEF_DEPTH   = 1024;
  localparam int DEF_LATENCY = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dmem_req_t;

  // A word access is legal only when it is word aligned and its word index
  // falls inside the array.
  function automatic logic addr_bad(input logic [31:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage for dmem_responder.
//   clk    in   rising-edge clock
//   reset  in   async active-low; clears only the read register, never storage
//   we     in   write mem[addr] <= wdata
//   re     in   register mem[addr] into rdata
//   clr    in   force rdata to zero (error response)
//   addr   in   word index
//   wdata  in   write data
//   rdata  out  registered read data, held between reads
module dmem_array #(
  parameter int DEPTH = 1024,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic             re,
  input  logic             clr,
  input  logic [IDX_W-1:0] addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH];

  // Storage has no reset so it survives a pipeline reset.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   rdata <= '0;
    else if (clr) rdata <= '0;
    else if (re)  rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: accepts one word load/store,
// waits LATENCY cycles, commits the access and pulses a response.
//   clk         in   rising-edge clock
//   reset       in   async active-low reset; abandons any access in flight
//   req_valid   in   load/store presented
//   req_write   in   1 = store, 0 = load
//   req_addr    in   byte address
//   req_wdata   in   store data
//   req_ready   out  idle; request accepted on this edge if req_valid
//   resp_valid  out  one-cycle completion pulse
//   resp_rdata  out  load data, held until the next response
//   resp_err    out  misaligned / out-of-range, valid with resp_valid
//   stall       out  req_valid & ~resp_valid
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int IDX_W   = $clog2(DEPTH),
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        stall
);

  localparam logic       HAS_WAIT = (LATENCY > 0);
  localparam logic [3:0] CNT_INIT = HAS_WAIT ? 4'(LATENCY - 1) : 4'd0;

  state_t    state;
  logic [3:0] cnt;
  dmem_req_t lat_q;
  dmem_req_t acc;
  logic      enter_resp;
  logic      acc_err;
  logic      arr_we, arr_re, arr_clr;

  // With zero latency the access commits on the accept edge itself, before
  // the latched copy exists, so the live request is used in IDLE.
  assign acc = (state == ST_IDLE) ? dmem_req_t'({req_write, req_addr, req_wdata}) : lat_q;

  assign enter_resp = ((state == ST_IDLE) && req_valid && !HAS_WAIT) ||
                      ((state == ST_WAIT) && (cnt == 4'd0));

  assign acc_err = addr_bad(acc.addr, DEPTH);

  assign arr_we  = enter_resp &  acc.write & ~acc_err;
  assign arr_re  = enter_resp & ~acc.write & ~acc_err;
  assign arr_clr = enter_resp &  acc_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      cnt        <= 4'd0;
      lat_q      <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= enter_resp;
      resp_err   <= enter_resp & acc_err;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            lat_q <= acc;
            cnt   <= CNT_INIT;
            state <= HAS_WAIT ? ST_WAIT : ST_RESP;
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) state <= ST_RESP;
          else             cnt   <= cnt - 4'd1;
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  dmem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (clk),
    .reset (reset),
    .we    (arr_we),
    .re    (arr_re),
    .clr   (arr_clr),
    .addr  (acc.addr[IDX_W+1:2]),
    .wdata (acc.wdata),
    .rdata (resp_rdata)
  );

  assign req_ready = (state == ST_IDLE);
  assign stall     = req_valid & ~resp_valid;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: LATENCY=2 instance for the main sequence, LATENCY=0
// instance for the zero-wait path.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_err, stall;
  logic [31:0] resp_rdata;

  logic        b_req_valid, b_req_write;
  logic [31:0] b_req_addr, b_req_wdata;
  logic        b_req_ready, b_resp_valid, b_resp_err, b_stall;
  logic [31:0] b_resp_rdata;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.DEPTH(1024), .IDX_W(10), .LATENCY(2)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .stall(stall)
  );

  dmem_responder #(.DEPTH(1024), .IDX_W(10), .LATENCY(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_write(b_req_write), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .req_ready(b_req_ready), .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata),
    .resp_err(b_resp_err), .stall(b_stall)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One access on the LATENCY=2 instance. Starts in an IDLE cycle ~1 time
  // unit after an edge and returns in the IDLE cycle after the response.
  // lat counts edges from accept to the response cycle; nst counts sampled
  // cycles with stall high; chg rewrites req_addr right after accept.
  task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic chg, output logic [31:0] rd, output logic e,
                      output int lat, output int nst, output int rcyc);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    nst = 0; lat = 0;
    #1;
    if (stall) nst++;
    @(posedge clk); #1;
    if (chg) req_addr = a ^ 32'h0000_0100;
    while (!resp_valid && lat < 20) begin
      if (stall) nst++;
      @(posedge clk); #1;
      lat++;
    end
    if (stall) nst++;
    rd = resp_rdata; e = resp_err; rcyc = cyc;
    req_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  logic [31:0] rd;
  logic        e;
  int          lat, nst;
  int          rc [8];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = 32'h0; b_req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("rst_ready",  32'(req_ready),  32'd1);
    chk("rst_rvalid", 32'(resp_valid), 32'd0);
    chk("rst_rdata",  resp_rdata,      32'h0);
    chk("rst_err",    32'(resp_err),   32'd0);
    chk("rst_stall",  32'(stall),      32'd1);
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("idle_ready", 32'(req_ready), 32'd1);

    // store then load at 0x40
    xact(1'b1, 32'h40, 32'hDEAD_BEEF, 1'b0, rd, e, lat, nst, rc[0]);
    chk("st40_lat",   32'(lat), 32'd2);
    chk("st40_err",   32'(e),   32'd0);
    chk("st40_stall", 32'(nst), 32'd3);
    xact(1'b0, 32'h40, 32'h0, 1'b0, rd, e, lat, nst, rc[0]);
    chk("ld40_data", rd,        32'hDEAD_BEEF);
    chk("ld40_err",  32'(e),    32'd0);
    chk("ld40_lat",  32'(lat),  32'd2);
    xact(1'b1, 32'h44, 32'h0102_0304, 1'b0, rd, e, lat, nst, rc[0]);
    chk("st_keeps_rdata", rd, 32'hDEAD_BEEF);

    // back-to-back: 4 stores then 4 loads, two with mid-WAIT address change
    for (int i = 0; i < 4; i++)
      xact(1'b1, 32'(4 * i), 32'hC0DE_0000 + 32'(i), (i == 1), rd, e, lat, nst, rc[i]);
    for (int i = 0; i < 4; i++) begin
      xact(1'b0, 32'(4 * i), 32'h0, (i == 2), rd, e, lat, nst, rc[4 + i]);
      chk($sformatf("b2b_ld%0d", i), rd, 32'hC0DE_0000 + 32'(i));
    end
    for (int i = 1; i < 8; i++)
      chk($sformatf("b2b_gap%0d", i), 32'(rc[i] - rc[i - 1]), 32'd4);

    // error cases; must not corrupt 0x40 or alias onto word 0
    xact(1'b1, 32'h42, 32'h0000_0BAD, 1'b0, rd, e, lat, nst, rc[0]);
    chk("mis_st_err",   32'(e), 32'd1);
    chk("mis_st_rdata", rd,     32'h0);
    xact(1'b0, 32'h1000, 32'h0, 1'b0, rd, e, lat, nst, rc[0]);
    chk("oor_ld_err",   32'(e), 32'd1);
    chk("oor_ld_rdata", rd,     32'h0);
    xact(1'b1, 32'h1000, 32'h0000_CAFE, 1'b0, rd, e, lat, nst, rc[0]);
    chk("oor_st_err", 32'(e), 32'd1);
    xact(1'b0, 32'h40, 32'h0, 1'b0, rd, e, lat, nst, rc[0]);
    chk("post_err_ld40",  rd,     32'hDEAD_BEEF);
    chk("post_err_err",   32'(e), 32'd0);
    xact(1'b0, 32'h0, 32'h0, 1'b0, rd, e, lat, nst, rc[0]);
    chk("no_alias_ld0", rd, 32'hC0DE_0000);
    xact(1'b1, 32'hFFC, 32'h7777_1234, 1'b0, rd, e, lat, nst, rc[0]);
    chk("last_st_err", 32'(e), 32'd0);
    xact(1'b0, 32'hFFC, 32'h0, 1'b0, rd, e, lat, nst, rc[0]);
    chk("last_ld", rd, 32'h7777_1234);

    // reset during WAIT abandons the store
    xact(1'b1, 32'h80, 32'h5555_AAAA, 1'b0, rd, e, lat, nst, rc[0]);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h80; req_wdata = 32'h11;
    @(posedge clk); #1;
    reset = 1'b0; req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_mid_rvalid", 32'(resp_valid), 32'd0);
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("post_rst_rvalid", 32'(resp_valid), 32'd0);
    end
    chk("post_rst_ready", 32'(req_ready), 32'd1);
    xact(1'b0, 32'h80, 32'h0, 1'b0, rd, e, lat, nst, rc[0]);
    chk("rst_no_write", rd, 32'h5555_AAAA);

    // LATENCY=0 instance
    b_req_valid = 1'b1; b_req_write = 1'b1; b_req_addr = 32'h8; b_req_wdata = 32'h1234_5678;
    #1 chk("l0_st_stall_pre", 32'(b_stall), 32'd1);
    @(posedge clk); #1;
    chk("l0_st_rvalid", 32'(b_resp_valid), 32'd1);
    chk("l0_st_stall",  32'(b_stall),      32'd0);
    chk("l0_st_err",    32'(b_resp_err),   32'd0);
    b_req_valid = 1'b0;
    @(posedge clk); #1;
    chk("l0_idle_rvalid", 32'(b_resp_valid), 32'd0);
    chk("l0_idle_ready",  32'(b_req_ready),  32'd1);
    b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = 32'h8;
    #1 chk("l0_ld_stall_pre", 32'(b_stall), 32'd1);
    @(posedge clk); #1;
    chk("l0_ld_rvalid", 32'(b_resp_valid), 32'd1);
    chk("l0_ld_rdata",  b_resp_rdata,      32'h1234_5678);
    chk("l0_ld_stall",  32'(b_stall),      32'd0);
    b_req_valid = 1'b0;
    @(posedge clk); #1;
    b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = 32'h3;
    @(posedge clk); #1;
    chk("l0_mis_err",   32'(b_resp_err), 32'd1);
    chk("l0_mis_rdata", b_resp_rdata,    32'h0);
    b_req_valid = 1'b0;
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
